// File: rtl/im_load_arbiter.sv
// Instruction-memory port owner: loads a program from a host word stream, releases the core, then
// shares IM between fetch and single-cycle host debug reads. Optional: IM_LOAD_CHECKSUM_EN.
module im_load_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
`ifdef IM_LOAD_CHECKSUM_EN
  input  logic [DATA_WIDTH-1:0] ld_csum_i,
`endif
  input  logic                  ld_valid_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  output logic                  ld_ready_o,
  input  logic                  dbg_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  output logic [DATA_WIDTH-1:0] im_wdata_o,
  output logic                  im_wr_o,
  output logic                  im_rd_o,
  input  logic [DATA_WIDTH-1:0] im_rdata_i,
  output logic                  cpu_rst_o,
  output logic                  start_o,
  output logic                  stall_pc_o,
  output logic                  flush_if_id_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_e;

  localparam logic [ADDR_WIDTH:0]   MaxLen  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LenOne  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] WcntOne = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                  err_q, err_d;
  logic                  gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic len_ok;
  logic can_load;
  logic load_accept;
  logic load_reject;
  logic word_acc;
  logic last_word;
  logic dbg_grant;

`ifdef IM_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [DATA_WIDTH-1:0] sum_next;
  assign sum_next = sum_q + ld_data_i;
`endif

  assign len_ok      = (load_len_i != '0) && (load_len_i <= MaxLen);
  assign can_load    = (state_q == StIdle) || (state_q == StRun);
  assign load_accept = can_load && load_req_i && len_ok;
  assign load_reject = can_load && load_req_i && !len_ok;
  assign word_acc    = (state_q == StLoad) && ld_valid_i;
  // Compare against the latched length, not the wrapped counter, so a full-depth load terminates.
  assign last_word   = word_acc && ({1'b0, wcnt_q} == (len_q - LenOne));
  // Any load request in RUN wins the port; grants are spaced so fetch always gets every other slot.
  assign dbg_grant   = (state_q == StRun) && dbg_rd_req_i && !gnt_q && !load_req_i;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    gnt_d   = 1'b0;
    rdata_d = rdata_q;
`ifdef IM_LOAD_CHECKSUM_EN
    sum_d   = sum_q;
    csum_d  = csum_q;
`endif

    unique case (state_q)
      StIdle:  ;
      StLoad: begin
        if (word_acc) begin
          wcnt_d = wcnt_q + WcntOne;
`ifdef IM_LOAD_CHECKSUM_EN
          sum_d  = sum_next;
          if (last_word) begin
            if (sum_next != csum_q) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StStart;
            end
          end
`else
          if (last_word) state_d = StStart;
`endif
        end
      end
      StStart: state_d = StRun;
      StRun:   gnt_d   = dbg_grant;
    endcase

    if (load_accept) begin
      state_d = StLoad;
      len_d   = load_len_i;
      wcnt_d  = '0;
      err_d   = 1'b0;
`ifdef IM_LOAD_CHECKSUM_EN
      sum_d   = '0;
      csum_d  = ld_csum_i;
`endif
    end else if (load_reject) begin
      err_d = 1'b1;
    end

    if (gnt_q) rdata_d = im_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      gnt_q   <= 1'b0;
      rdata_q <= '0;
`ifdef IM_LOAD_CHECKSUM_EN
      sum_q   <= '0;
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
`ifdef IM_LOAD_CHECKSUM_EN
      sum_q   <= sum_d;
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    ld_ready_o    = 1'b0;
    im_wr_o       = 1'b0;
    im_rd_o       = 1'b0;
    im_addr_o     = '0;
    im_wdata_o    = '0;
    cpu_rst_o     = 1'b0;
    start_o       = 1'b0;
    stall_pc_o    = 1'b0;
    flush_if_id_o = 1'b0;
    busy_o        = 1'b0;
    dbg_gnt_o     = 1'b0;

    unique case (state_q)
      StIdle: cpu_rst_o = 1'b1;
      StLoad: begin
        cpu_rst_o  = 1'b1;
        ld_ready_o = 1'b1;
        busy_o     = 1'b1;
        im_wr_o    = word_acc;
        im_addr_o  = wcnt_q;
        if (word_acc) im_wdata_o = ld_data_i;
      end
      StStart: begin
        start_o       = 1'b1;
        flush_if_id_o = 1'b1;
        busy_o        = 1'b1;
      end
      StRun: begin
        im_rd_o       = 1'b1;
        im_addr_o     = dbg_grant ? dbg_addr_i : if_addr_i;
        dbg_gnt_o     = dbg_grant;
        stall_pc_o    = dbg_grant;
        flush_if_id_o = dbg_grant;
      end
    endcase
  end

  assign err_o        = err_q;
  assign dbg_rvalid_o = gnt_q;
  // Read data arrives one cycle after the grant; afterwards the captured copy is held.
  assign dbg_rdata_o  = gnt_q ? im_rdata_i : rdata_q;

  a_no_wr_rd: assert property (@(posedge clk) disable iff (!rst_n) !(im_wr_o && im_rd_o));
  a_gnt_spaced: assert property (@(posedge clk) disable iff (!rst_n) dbg_gnt_o |=> !dbg_gnt_o);

endmodule

// File: tb/tb_im_load_arbiter.sv
// Self-checking bench for im_load_arbiter: IM model plus a host-level reference of loads and reads.
module tb_im_load_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req_i;
  logic [AW:0]   load_len_i;
  logic          ld_valid_i;
  logic [DW-1:0] ld_data_i;
  logic          ld_ready_o;
  logic          dbg_rd_req_i;
  logic [AW-1:0] dbg_addr_i;
  logic          dbg_gnt_o;
  logic          dbg_rvalid_o;
  logic [DW-1:0] dbg_rdata_o;
  logic [AW-1:0] if_addr_i;
  logic [AW-1:0] im_addr_o;
  logic [DW-1:0] im_wdata_o;
  logic          im_wr_o;
  logic          im_rd_o;
  logic [DW-1:0] im_rdata_i = '0;
  logic          cpu_rst_o;
  logic          start_o;
  logic          stall_pc_o;
  logic          flush_if_id_o;
  logic          busy_o;
  logic          err_o;
`ifdef IM_LOAD_CHECKSUM_EN
  logic [DW-1:0] ld_csum_i;
`endif

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  logic [DW-1:0] im_mem  [Depth] = '{default: '0};
  logic [DW-1:0] exp_mem [Depth] = '{default: '0};
  logic [DW-1:0] words[$];

  im_load_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req_i   (load_req_i),
    .load_len_i   (load_len_i),
`ifdef IM_LOAD_CHECKSUM_EN
    .ld_csum_i    (ld_csum_i),
`endif
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_ready_o   (ld_ready_o),
    .dbg_rd_req_i (dbg_rd_req_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_gnt_o    (dbg_gnt_o),
    .dbg_rvalid_o (dbg_rvalid_o),
    .dbg_rdata_o  (dbg_rdata_o),
    .if_addr_i    (if_addr_i),
    .im_addr_o    (im_addr_o),
    .im_wdata_o   (im_wdata_o),
    .im_wr_o      (im_wr_o),
    .im_rd_o      (im_rd_o),
    .im_rdata_i   (im_rdata_i),
    .cpu_rst_o    (cpu_rst_o),
    .start_o      (start_o),
    .stall_pc_o   (stall_pc_o),
    .flush_if_id_o(flush_if_id_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (im_wr_o) begin
      im_mem[im_addr_o] <= im_wdata_o;
      wr_count <= wr_count + 1;
    end
    if (im_rd_o) im_rdata_i <= im_mem[im_addr_o];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a whole load from IDLE or RUN using the queue 'words', checking LOAD, START and RUN entry.
  task automatic run_load(input int len, input int gap);
    int idx;
    int gcnt;
    bit vld;
`ifdef IM_LOAD_CHECKSUM_EN
    logic [DW-1:0] sum;
    sum = '0;
    for (int i = 0; i < len; i++) sum = sum + words[i];
    ld_csum_i = sum;
`endif
    load_req_i = 1'b1;
    load_len_i = (AW + 1)'(len);
    if_addr_i  = AW'($urandom);
    @(negedge clk);
    checks++;
    if (dbg_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL load_beats_dbg: gnt=%b want 0", dbg_gnt_o);
    end
    step();
    idx  = 0;
    gcnt = 0;
    while (idx < len) begin
      vld        = (gap >= 0) ? (gcnt == 0) : ($urandom_range(0, 2) != 0);
      ld_valid_i = vld;
      ld_data_i  = vld ? words[idx] : DW'($urandom);
      load_req_i = ($urandom_range(0, 7) == 0);
      load_len_i = (AW + 1)'($urandom);
      @(negedge clk);
      checks++;
      if ({cpu_rst_o, ld_ready_o, busy_o, start_o, im_rd_o, err_o, dbg_gnt_o, im_wr_o} !==
          {7'b1110000, vld}) begin
        failures++;
        $display("FAIL load_cycle[%0d]: rst/rdy/busy/start/rd/err/gnt/wr=%b want %b", idx,
                 {cpu_rst_o, ld_ready_o, busy_o, start_o, im_rd_o, err_o, dbg_gnt_o, im_wr_o},
                 {7'b1110000, vld});
      end
      if (vld) begin
        checks++;
        if (im_addr_o !== AW'(idx) || im_wdata_o !== words[idx]) begin
          failures++;
          $display("FAIL load_write[%0d]: addr=%0d data=%h want addr=%0d data=%h", idx, im_addr_o,
                   im_wdata_o, idx % Depth, words[idx]);
        end
        exp_mem[idx] = words[idx];
        idx++;
        gcnt = gap;
      end else if (gcnt > 0) begin
        gcnt--;
      end
      step();
    end
    ld_valid_i = 1'b0;
    load_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_rst_o, start_o, flush_if_id_o, busy_o, ld_ready_o, im_wr_o, dbg_gnt_o, stall_pc_o} !==
        8'b01110000) begin
      failures++;
      $display("FAIL start_cycle: rst/start/flush/busy/rdy/wr/gnt/stall=%b want 01110000",
               {cpu_rst_o, start_o, flush_if_id_o, busy_o, ld_ready_o, im_wr_o, dbg_gnt_o,
                stall_pc_o});
    end
    step();
    dbg_rd_req_i = 1'b0;
    if_addr_i    = AW'($urandom);
    @(negedge clk);
    checks++;
    if ({cpu_rst_o, start_o, busy_o, im_rd_o, flush_if_id_o} !== 5'b00010 ||
        im_addr_o !== if_addr_i) begin
      failures++;
      $display("FAIL run_entry: rst/start/busy/rd/flush=%b addr=%0d want 00010 addr=%0d",
               {cpu_rst_o, start_o, busy_o, im_rd_o, flush_if_id_o}, im_addr_o, if_addr_i);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    load_req_i   = 1'b0;
    load_len_i   = '0;
    ld_valid_i   = 1'b0;
    ld_data_i    = '0;
    dbg_rd_req_i = 1'b0;
    dbg_addr_i   = '0;
    if_addr_i    = '0;
`ifdef IM_LOAD_CHECKSUM_EN
    ld_csum_i    = '0;
`endif
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if_addr_i = AW'($urandom);
      @(negedge clk);
      checks++;
      if ({cpu_rst_o, start_o, im_wr_o, im_rd_o, busy_o, ld_ready_o, err_o, dbg_rvalid_o,
           dbg_gnt_o, stall_pc_o, flush_if_id_o} !== 11'b10000000000 || dbg_rdata_o !== '0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: flags=%b rdata=%h want 10000000000 rdata=0000", c,
                 {cpu_rst_o, start_o, im_wr_o, im_rd_o, busy_o, ld_ready_o, err_o, dbg_rvalid_o,
                  dbg_gnt_o, stall_pc_o, flush_if_id_o}, dbg_rdata_o);
      end
      step();
    end
  endtask

  task automatic test_invalid_len();
    logic [AW:0] bad [3];
    bad[0] = '0;
    bad[1] = (AW + 1)'(Depth + 1);
    bad[2] = (AW + 1)'($urandom_range(Depth + 2, 2 * Depth - 1));
    for (int i = 0; i < 3; i++) begin
      load_req_i = 1'b1;
      load_len_i = bad[i];
      step();
      load_req_i = 1'b0;
      ld_valid_i = 1'b1;
      ld_data_i  = DW'($urandom);
      @(negedge clk);
      checks++;
      if ({err_o, cpu_rst_o, busy_o, ld_ready_o, im_wr_o} !== 5'b11000) begin
        failures++;
        $display("FAIL idle_bad_len[%0d]: err/rst/busy/rdy/wr=%b want 11000", bad[i],
                 {err_o, cpu_rst_o, busy_o, ld_ready_o, im_wr_o});
      end
      step();
      ld_valid_i = 1'b0;
    end
  endtask

  task automatic test_full_load();
    words.delete();
    for (int i = 0; i < Depth; i++) words.push_back(DW'($urandom));
    run_load(Depth, -1);
  endtask

  task automatic test_basic_load();
    words.delete();
    words.push_back(16'h1111);
    words.push_back(16'h2222);
    words.push_back(16'h3333);
    run_load(3, 1);
  endtask

  task automatic test_run_fetch();
    for (int c = 0; c < 8; c++) begin
      if_addr_i = AW'($urandom);
      @(negedge clk);
      checks++;
      if ({im_rd_o, im_wr_o, cpu_rst_o, stall_pc_o, flush_if_id_o, dbg_gnt_o} !== 6'b100000 ||
          im_addr_o !== if_addr_i) begin
        failures++;
        $display("FAIL run_fetch[%0d]: rd/wr/rst/stall/flush/gnt=%b addr=%0d want 100000 addr=%0d",
                 c, {im_rd_o, im_wr_o, cpu_rst_o, stall_pc_o, flush_if_id_o, dbg_gnt_o},
                 im_addr_o, if_addr_i);
      end
      step();
    end
  endtask

  task automatic test_dbg_held();
    bit g;
    bit rv;
    for (int k = 0; k < 5; k++) begin
      dbg_rd_req_i = (k < 4);
      dbg_addr_i   = 8'h02;
      if_addr_i    = AW'($urandom);
      g  = (k == 0) || (k == 2);
      rv = (k == 1) || (k == 3);
      @(negedge clk);
      checks++;
      if ({dbg_gnt_o, stall_pc_o, flush_if_id_o, dbg_rvalid_o} !== {g, g, g, rv} ||
          im_addr_o !== (g ? 8'h02 : if_addr_i)) begin
        failures++;
        $display("FAIL dbg_held[%0d]: gnt/stall/flush/rvalid=%b addr=%0d want %b addr=%0d", k,
                 {dbg_gnt_o, stall_pc_o, flush_if_id_o, dbg_rvalid_o}, im_addr_o,
                 {g, g, g, rv}, g ? 8'h02 : if_addr_i);
      end
      if (k > 0) begin
        checks++;
        if (dbg_rdata_o !== 16'h3333) begin
          failures++;
          $display("FAIL dbg_held_data[%0d]: got %h want 3333", k, dbg_rdata_o);
        end
      end
      step();
    end
  endtask

  task automatic test_dbg_random();
    bit pend = 1'b0;
    bit pg = 1'b0;
    bit g;
    logic [AW-1:0] a = '0;
    logic [AW-1:0] pa = '0;
    for (int c = 0; c < 60; c++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        a    = AW'($urandom);
      end
      dbg_rd_req_i = pend;
      dbg_addr_i   = pend ? a : AW'($urandom);
      if_addr_i    = AW'($urandom);
      g = pend && !pg;
      @(negedge clk);
      checks++;
      if ({dbg_gnt_o, stall_pc_o, flush_if_id_o, dbg_rvalid_o} !== {g, g, g, pg} ||
          im_addr_o !== (g ? a : if_addr_i)) begin
        failures++;
        $display("FAIL dbg_rand[%0d]: gnt/stall/flush/rvalid=%b addr=%0d want %b addr=%0d", c,
                 {dbg_gnt_o, stall_pc_o, flush_if_id_o, dbg_rvalid_o}, im_addr_o,
                 {g, g, g, pg}, g ? a : if_addr_i);
      end
      if (pg) begin
        checks++;
        if (dbg_rdata_o !== exp_mem[pa]) begin
          failures++;
          $display("FAIL dbg_rand_data[%0d]: addr=%0d got %h want %h", c, pa, dbg_rdata_o,
                   exp_mem[pa]);
        end
      end
      if (g) pend = 1'b0;
      pg = g;
      pa = a;
      step();
    end
    dbg_rd_req_i = 1'b0;
    step();
  endtask

  task automatic test_run_invalid_len();
    load_req_i = 1'b1;
    load_len_i = ($urandom_range(0, 1) == 1) ? (AW + 1)'(Depth + 1) : '0;
    step();
    load_req_i = 1'b0;
    if_addr_i  = AW'($urandom);
    @(negedge clk);
    checks++;
    if ({err_o, cpu_rst_o, im_rd_o, busy_o, ld_ready_o} !== 5'b10100 ||
        im_addr_o !== if_addr_i) begin
      failures++;
      $display("FAIL run_bad_len: err/rst/rd/busy/rdy=%b addr=%0d want 10100 addr=%0d",
               {err_o, cpu_rst_o, im_rd_o, busy_o, ld_ready_o}, im_addr_o, if_addr_i);
    end
    step();
  endtask

  task automatic test_abort_with_dbg();
    int len;
    len = $urandom_range(1, 16);
    words.delete();
    for (int i = 0; i < len; i++) words.push_back(DW'($urandom));
    dbg_rd_req_i = 1'b1;
    dbg_addr_i   = AW'($urandom);
    run_load(len, -1);
  endtask

  task automatic test_reset_mid_load();
    int wc0;
    words.delete();
    for (int i = 0; i < 10; i++) words.push_back(DW'($urandom));
    load_req_i = 1'b1;
    load_len_i = (AW + 1)'(10);
    step();
    load_req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = words[k];
      @(negedge clk);
      checks++;
      if (im_wr_o !== 1'b1 || im_addr_o !== AW'(k) || cpu_rst_o !== 1'b1) begin
        failures++;
        $display("FAIL abort_load_wr[%0d]: wr=%b addr=%0d rst=%b want 1 %0d 1", k, im_wr_o,
                 im_addr_o, cpu_rst_o, k);
      end
      exp_mem[k] = words[k];
      step();
    end
    ld_valid_i = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    wc0 = wr_count;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = DW'($urandom);
      @(negedge clk);
      checks++;
      if ({im_wr_o, ld_ready_o, cpu_rst_o, busy_o, start_o, err_o} !== 6'b001000) begin
        failures++;
        $display("FAIL reset_mid_load[%0d]: wr/rdy/rst/busy/start/err=%b want 001000", c,
                 {im_wr_o, ld_ready_o, cpu_rst_o, busy_o, start_o, err_o});
      end
      step();
    end
    ld_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_count !== wc0) begin
      failures++;
      $display("FAIL reset_no_writes: writes=%0d want %0d", wr_count, wc0);
    end
    step();
  endtask

`ifdef IM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    load_req_i = 1'b1;
    load_len_i = (AW + 1)'(2);
    ld_csum_i  = 16'h0004;
    step();
    load_req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = DW'(k + 1);
      exp_mem[k] = DW'(k + 1);
      step();
    end
    ld_valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({err_o, start_o, cpu_rst_o, busy_o, ld_ready_o} !== 5'b10100) begin
        failures++;
        $display("FAIL csum_bad[%0d]: err/start/rst/busy/rdy=%b want 10100", c,
                 {err_o, start_o, cpu_rst_o, busy_o, ld_ready_o});
      end
      step();
    end
    words.delete();
    words.push_back(16'h0001);
    words.push_back(16'h0002);
    run_load(2, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_invalid_len();
    test_full_load();
    test_basic_load();
    test_run_fetch();
    test_dbg_held();
    test_dbg_random();
    test_run_invalid_len();
    test_abort_with_dbg();
    test_reset_mid_load();
`ifdef IM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
